// File: rtl/clkgen_pkg.sv
// Shared types and board-level defaults for the step/auto clock generator.
// Default timing is derived here so that the board constants live in one place.
package clkgen_pkg;

  typedef enum logic [2:0] {IDLE, ARM, PULSE, HELD, REL} step_state_t;

  localparam int CLK_HZ      = 50_000_000;
  localparam int DEBOUNCE_MS = 10;
  localparam int AUTO_HZ     = 100;

  function automatic int calc_div_half(input int clk_hz, input int auto_hz);
    return clk_hz / (2 * auto_hz);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clkdiv.sv
// Free-running divider: toggles its output every DIV_HALF cycles for a 50% duty clock.
// The output is a flop, so it is safe to feed straight into the clock mux.
module clkdiv #(
  parameter int DIV_HALF = 250_000
) (
  input  logic clk,
  input  logic rst,
  output logic clk_div_out
);

  localparam int DW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam logic [DW-1:0] TERM = DW'(DIV_HALF - 1);

  logic [DW-1:0] dcount_reg;
  logic          out_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      dcount_reg <= '0;
      out_reg    <= 1'b0;
    end else if (dcount_reg == TERM) begin
      dcount_reg <= '0;
      out_reg    <= ~out_reg;
    end else begin
      dcount_reg <= dcount_reg + DW'(1);
    end
  end

  assign clk_div_out = out_reg;

endmodule

// File: rtl/step_clkgen.sv
// Produces the single-step clock (one debounced, fixed-width pulse per button press)
// and the free-running divided clock that the downstream clock mux chooses between.
module step_clkgen
  import clkgen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = (CLK_HZ / 1000) * DEBOUNCE_MS,
  parameter int STEP_HIGH_CYCLES = 25_000,
  parameter int DIV_HALF         = calc_div_half(CLK_HZ, AUTO_HZ),
  parameter int CNT_W            = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_n,
  output logic             step_clk,
  output logic             auto_clk,
  output logic [CNT_W-1:0] press_cnt,
  output logic             busy
);

  localparam int DCNT_MAX = max_int(DEBOUNCE_CYCLES, STEP_HIGH_CYCLES);
  localparam int DCNT_W   = (DCNT_MAX > 1) ? $clog2(DCNT_MAX) : 1;
  localparam logic [DCNT_W-1:0] DEB_LAST  = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DCNT_W-1:0] STEP_LAST = DCNT_W'(STEP_HIGH_CYCLES - 1);

  logic              key_meta_reg;
  logic              key_s_reg;
  step_state_t       state_reg;
  step_state_t       state_next;
  logic [DCNT_W-1:0] dcnt_reg;
  logic [DCNT_W-1:0] dcnt_next;
  logic [CNT_W-1:0]  press_cnt_reg;
  logic              press_inc;
  logic              step_clk_reg;
  logic              busy_reg;

  // Outputs are registered from the next-state so they track the state register exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_meta_reg  <= 1'b1;
      key_s_reg     <= 1'b1;
      state_reg     <= IDLE;
      dcnt_reg      <= '0;
      press_cnt_reg <= '0;
      step_clk_reg  <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      key_meta_reg  <= key_n;
      key_s_reg     <= key_meta_reg;
      state_reg     <= state_next;
      dcnt_reg      <= dcnt_next;
      if (press_inc) press_cnt_reg <= press_cnt_reg + CNT_W'(1);
      step_clk_reg  <= (state_next == PULSE);
      busy_reg      <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next = state_reg;
    dcnt_next  = dcnt_reg;
    press_inc  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!key_s_reg) begin
          state_next = ARM;
          dcnt_next  = '0;
        end
      end
      ARM: begin
        if (key_s_reg) begin
          state_next = IDLE;
          dcnt_next  = '0;
        end else if (dcnt_reg == DEB_LAST) begin
          state_next = PULSE;
          dcnt_next  = '0;
          press_inc  = 1'b1;
        end else begin
          dcnt_next = dcnt_reg + DCNT_W'(1);
        end
      end
      PULSE: begin
        // Key is ignored here so the pulse always runs to full width.
        if (dcnt_reg == STEP_LAST) begin
          state_next = HELD;
          dcnt_next  = '0;
        end else begin
          dcnt_next = dcnt_reg + DCNT_W'(1);
        end
      end
      HELD: begin
        if (key_s_reg) begin
          state_next = REL;
          dcnt_next  = '0;
        end
      end
      REL: begin
        if (!key_s_reg) begin
          state_next = HELD;
          dcnt_next  = '0;
        end else if (dcnt_reg == DEB_LAST) begin
          state_next = IDLE;
          dcnt_next  = '0;
        end else begin
          dcnt_next = dcnt_reg + DCNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        dcnt_next  = '0;
      end
    endcase
  end

  clkdiv #(
    .DIV_HALF(DIV_HALF)
  ) u_clkdiv (
    .clk        (clk),
    .rst        (rst),
    .clk_div_out(auto_clk)
  );

  assign step_clk  = step_clk_reg;
  assign press_cnt = press_cnt_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_step_clkgen.sv
// Directed bench for step_clkgen with short debounce/pulse/divider settings.
// Expected latencies and widths are hand-derived from the timing rules.
module tb_step_clkgen;

  logic       clk;
  logic       rst;
  logic       key_n;
  logic       step_clk;
  logic       auto_clk;
  logic [7:0] press_cnt;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulses = 0;
  logic step_prev = 1'b0;
  logic div_en = 1'b0;

  step_clkgen #(
    .DEBOUNCE_CYCLES (8),
    .STEP_HIGH_CYCLES(4),
    .DIV_HALF        (5),
    .CNT_W           (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_n    (key_n),
    .step_clk (step_clk),
    .auto_clk (auto_clk),
    .press_cnt(press_cnt),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // Step pulse counter and continuous divider reference.
  always @(negedge clk) begin
    if (step_clk && !step_prev) pulses++;
    step_prev = step_clk;
    if (div_en) check("auto_clk", int'(auto_clk), (cyc / 5) % 2);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // sel: 0 step_clk, 1 busy, 2 auto_clk
  function automatic logic sig(input int sel);
    case (sel)
      0: return step_clk;
      1: return busy;
      default: return auto_clk;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic lvl, input int limit, output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (sig(sel) !== lvl && n < limit);
    if (sig(sel) !== lvl) check("wait_timeout", int'(sig(sel)), int'(lvl));
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    key_n = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  int n, w, p0;

  initial begin
    rst   = 1'b1;
    key_n = 1'b1;
    tick(3);
    check("rst_step_clk", int'(step_clk), 0);
    check("rst_auto_clk", int'(auto_clk), 0);
    check("rst_press_cnt", int'(press_cnt), 0);
    check("rst_busy", int'(busy), 0);
    div_en = 1'b1;
    rst = 1'b0;

    // Divider: first rise 5 cycles after reset release (also checked every cycle).
    wait_sig(2, 1'b1, 20, n);
    check("t4_auto_first_rise", n, 5);
    $display("divider first rise after %0d cycles", n);

    // 1. Clean press, 40-cycle hold.
    p0 = pulses;
    key_n = 1'b0;
    wait_sig(0, 1'b1, 40, n);
    check("t1_rise_latency", n, 11);
    wait_sig(0, 1'b0, 20, w);
    check("t1_width", w, 4);
    check("t1_press_cnt", int'(press_cnt), 1);
    check("t1_busy_held", int'(busy), 1);
    tick(40 - n - w);
    key_n = 1'b1;
    tick(10);
    check("t1_busy_rel", int'(busy), 1);
    tick(1);
    check("t1_busy_idle", int'(busy), 0);
    check("t1_pulses", pulses - p0, 1);
    $display("t1 clean press: latency=%0d width=%0d press_cnt=%0d", n, w, press_cnt);

    // 2. Bouncing press.
    do_reset();
    p0 = pulses;
    for (int s = 0; s < 10; s++) begin
      key_n = s[0];
      tick(3);
    end
    check("t2_no_pulse_bounce", pulses - p0, 0);
    check("t2_cnt_bounce", int'(press_cnt), 0);
    key_n = 1'b0;
    wait_sig(0, 1'b1, 40, n);
    check("t2_rise_latency", n, 11);
    wait_sig(0, 1'b0, 20, w);
    check("t2_width", w, 4);
    check("t2_press_cnt", int'(press_cnt), 1);
    key_n = 1'b1;
    wait_sig(1, 1'b0, 40, n);
    check("t2_pulses", pulses - p0, 1);
    $display("t2 bounce press: width=%0d press_cnt=%0d", w, press_cnt);

    // 3. Release bounce.
    do_reset();
    p0 = pulses;
    key_n = 1'b0;
    wait_sig(0, 1'b1, 40, n);
    wait_sig(0, 1'b0, 20, w);
    tick(3);
    key_n = 1'b1;
    tick(2);
    key_n = 1'b0;
    tick(2);
    key_n = 1'b1;
    tick(10);
    check("t3_busy_rel", int'(busy), 1);
    tick(1);
    check("t3_busy_idle", int'(busy), 0);
    check("t3_pulses", pulses - p0, 1);
    check("t3_press_cnt", int'(press_cnt), 1);
    $display("t3 release bounce: pulses=%0d press_cnt=%0d", pulses - p0, press_cnt);

    // 5. Counter wrap over 256 presses.
    do_reset();
    p0 = pulses;
    for (int i = 1; i <= 256; i++) begin
      key_n = 1'b0;
      wait_sig(0, 1'b1, 40, n);
      wait_sig(0, 1'b0, 20, w);
      key_n = 1'b1;
      wait_sig(1, 1'b0, 40, n);
      if (i == 255) check("t5_cnt_255", int'(press_cnt), 255);
    end
    check("t5_cnt_wrap", int'(press_cnt), 0);
    check("t5_pulses", pulses - p0, 256);
    $display("t5 wrap: pulses=%0d press_cnt=%0d", pulses - p0, press_cnt);

    // 6. Reset in the second PULSE cycle with key held.
    do_reset();
    key_n = 1'b0;
    wait_sig(0, 1'b1, 40, n);
    tick(1);
    check("t6_pulse_2nd", int'(step_clk), 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_rst_step_clk", int'(step_clk), 0);
    check("t6_rst_press_cnt", int'(press_cnt), 0);
    check("t6_rst_busy", int'(busy), 0);
    wait_sig(0, 1'b1, 40, n);
    check("t6_rise_latency", n, 11);
    wait_sig(0, 1'b0, 20, w);
    check("t6_width", w, 4);
    check("t6_press_cnt", int'(press_cnt), 1);
    key_n = 1'b1;
    wait_sig(1, 1'b0, 40, n);
    $display("t6 reset mid-pulse: width=%0d press_cnt=%0d", w, press_cnt);

    tick(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
